// File: rtl/led_status_pwm.sv
// Status LED driver: mode FSM (INIT/RUN/CALIB/FAULT) with PWM dimming, a breathing envelope in CALIB
// and blink patterns in INIT/FAULT. All LED pins and o_mode come straight from flops.
module led_status_pwm #(
  parameter int PRESCALE_TICKS = 50,
  parameter int DUTY_WIDTH     = 8,
  parameter int BLINK_PERIODS  = 32,
  parameter int BREATH_STEP    = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_adc_init_done,
  input  logic                  i_calib_enabled,
  input  logic                  i_fault,
  input  logic                  i_fault_clear,
  input  logic [DUTY_WIDTH-1:0] i_brightness,
  output logic                  o_led_r,
  output logic                  o_led_g,
  output logic                  o_led_b,
  output logic [1:0]            o_mode
);

  localparam int PW            = (PRESCALE_TICKS > 1) ? $clog2(PRESCALE_TICKS) : 1;
  localparam int BW            = $clog2(BLINK_PERIODS + 1);
  localparam int FAULT_PERIODS = (BLINK_PERIODS / 4 > 0) ? BLINK_PERIODS / 4 : 1;

  localparam logic [PW-1:0]         PRESC_LAST = PW'(PRESCALE_TICKS - 1);
  localparam logic [DUTY_WIDTH-1:0] DUTY_MAX   = '1;
  localparam logic [DUTY_WIDTH:0]   STEP_EXT   = (DUTY_WIDTH + 1)'(BREATH_STEP);
  localparam logic [DUTY_WIDTH-1:0] STEP_W     = DUTY_WIDTH'(BREATH_STEP);
  localparam logic [BW-1:0]         INIT_LAST  = BW'(BLINK_PERIODS - 1);
  localparam logic [BW-1:0]         FAULT_LAST = BW'(FAULT_PERIODS - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CALIB = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [PW-1:0]           presc_reg;
  logic [DUTY_WIDTH-1:0]   pwm_cnt_reg;
  logic [DUTY_WIDTH-1:0]   duty_reg;
  logic [DUTY_WIDTH-1:0]   envelope_reg, envelope_next;
  logic                    dir_up_reg, dir_up_next;
  logic [BW-1:0]           blink_cnt_reg, blink_cnt_next;
  logic                    blink_phase_reg, blink_phase_next;
  logic                    fault_flag_reg;
  logic                    led_r_reg, led_g_reg, led_b_reg;
  logic                    led_r_next, led_g_next, led_b_next;

  logic                    step;
  logic                    period_end;
  logic [DUTY_WIDTH:0]     env_sum;
  logic [BW-1:0]           blink_last;

  assign step       = (presc_reg == PRESC_LAST);
  assign period_end = step && (pwm_cnt_reg == DUTY_MAX);
  assign env_sum    = {1'b0, envelope_reg} + STEP_EXT;
  assign blink_last = (state_reg == ST_FAULT) ? FAULT_LAST : INIT_LAST;

  // State register plus all datapath registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg       <= ST_INIT;
      presc_reg       <= '0;
      pwm_cnt_reg     <= '0;
      duty_reg        <= '0;
      envelope_reg    <= '0;
      dir_up_reg      <= 1'b1;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
      fault_flag_reg  <= 1'b0;
      led_r_reg       <= 1'b0;
      led_g_reg       <= 1'b0;
      led_b_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      presc_reg       <= step ? '0 : presc_reg + 1'b1;
      if (step)
        pwm_cnt_reg   <= pwm_cnt_reg + 1'b1;
      // Duty only changes on a period boundary so a period is never cut short.
      if (period_end)
        duty_reg      <= (state_reg == ST_CALIB) ? envelope_reg : i_brightness;
      envelope_reg    <= envelope_next;
      dir_up_reg      <= dir_up_next;
      blink_cnt_reg   <= blink_cnt_next;
      blink_phase_reg <= blink_phase_next;
      // A fault still asserted wins over a simultaneous clear.
      if (i_fault)
        fault_flag_reg <= 1'b1;
      else if (i_fault_clear)
        fault_flag_reg <= 1'b0;
      led_r_reg       <= led_r_next;
      led_g_reg       <= led_g_next;
      led_b_reg       <= led_b_next;
    end
  end

  always_comb begin
    if (fault_flag_reg)
      state_next = ST_FAULT;
    else if (!i_adc_init_done)
      state_next = ST_INIT;
    else if (i_calib_enabled)
      state_next = ST_CALIB;
    else
      state_next = ST_RUN;
  end

  // Envelope and blink sequencing; every mode change restarts both patterns.
  always_comb begin
    envelope_next    = envelope_reg;
    dir_up_next      = dir_up_reg;
    blink_cnt_next   = blink_cnt_reg;
    blink_phase_next = blink_phase_reg;
    if (state_next != state_reg) begin
      envelope_next    = '0;
      dir_up_next      = 1'b1;
      blink_cnt_next   = '0;
      blink_phase_next = 1'b1;
    end else if (period_end) begin
      if (state_reg == ST_CALIB) begin
        if (dir_up_reg) begin
          if (env_sum >= {1'b0, DUTY_MAX}) begin
            envelope_next = DUTY_MAX;
            dir_up_next   = 1'b0;
          end else begin
            envelope_next = env_sum[DUTY_WIDTH-1:0];
          end
        end else begin
          if ({1'b0, envelope_reg} <= STEP_EXT) begin
            envelope_next = '0;
            dir_up_next   = 1'b1;
          end else begin
            envelope_next = envelope_reg - STEP_W;
          end
        end
      end
      if (blink_cnt_reg == blink_last) begin
        blink_cnt_next   = '0;
        blink_phase_next = ~blink_phase_reg;
      end else begin
        blink_cnt_next   = blink_cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    led_r_next = 1'b0;
    led_g_next = 1'b0;
    led_b_next = 1'b0;
    case (state_reg)
      ST_INIT:  led_r_next = blink_phase_reg && (pwm_cnt_reg < DUTY_MAX);
      ST_RUN:   led_g_next = (pwm_cnt_reg < duty_reg);
      ST_CALIB: led_b_next = (pwm_cnt_reg < duty_reg);
      default:  led_r_next = blink_phase_reg;
    endcase
  end

  assign o_led_r = led_r_reg;
  assign o_led_g = led_g_reg;
  assign o_led_b = led_b_reg;
  assign o_mode  = state_reg;

endmodule

// File: doc/led_status_pwm.md
LED_STATUS_PWM -- requirements
Module: led_status_pwm

Interface
REQ-001 SHALL have parameter PRESCALE_TICKS, default 50, clocks per PWM step (min 1).
REQ-002 SHALL have parameter DUTY_WIDTH, default 8, PWM counter/duty width (min 2).
REQ-003 SHALL have parameter BLINK_PERIODS, default 32, PWM periods per blink half-cycle (min 1).
REQ-004 SHALL have parameter BREATH_STEP, default 4, envelope increment per PWM period (1..2^DUTY_WIDTH-1).
REQ-005 SHALL have the following ports:
- i_clock  in  1  sole clock; all logic on its rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_adc_init_done  in  1  ADC initialisation complete.
- i_calib_enabled  in  1  calibration mode request.
- i_fault  in  1  fault request; level, sampled each cycle.
- i_fault_clear  in  1  clears a latched fault.
- i_brightness  in  DUTY_WIDTH  duty for steady green.
- o_led_r, o_led_g, o_led_b  out  1 each  registered LED drives.
- o_mode  out  2  current state: 0 INIT, 1 RUN, 2 CALIB, 3 FAULT.

Function
REQ-006 SHALL run prescaler 0..PRESCALE_TICKS-1, wrapping to 0; step pulse is 1 in the cycle the prescaler equals PRESCALE_TICKS-1.
REQ-007 SHALL increment DUTY_WIDTH-bit pwm_cnt on each step pulse; 2^DUTY_WIDTH-1 wraps to 0; period_end = step pulse AND pwm_cnt all-ones.
REQ-008 SHALL compute a channel as on when pwm_cnt < active duty (unsigned): duty 0 never on; duty all-ones on 2^W-1 of 2^W steps.
REQ-009 SHALL latch active duty only at period_end (no mid-period duty change); reset value 0.
REQ-010 SHALL latch fault_flag on i_fault=1; clear it only when i_fault_clear=1 and i_fault=0 in the same cycle; simultaneous set and clear keeps it set.
REQ-011 SHALL select next state each cycle, priority: fault_flag -> FAULT; else !i_adc_init_done -> INIT; else i_calib_enabled -> CALIB; else RUN.
REQ-012 SHALL, on any state change, reset envelope to 0, direction to up, blink_cnt to 0, blink_phase to 1; PWM counters SHALL NOT be reset.
REQ-013 INIT: red on when blink_phase=1 and PWM compare true at duty all-ones; green, blue 0.
REQ-014 RUN: green = PWM compare against latched i_brightness; red, blue 0.
REQ-015 CALIB: blue = PWM compare against envelope; red, green 0.
REQ-016 FAULT: red = blink_phase with no PWM gating (full on/off); blink toggles every BLINK_PERIODS/4 periods, minimum 1; green, blue 0.
REQ-017 Envelope SHALL update at period_end only in CALIB: up adds BREATH_STEP, saturates at all-ones, then direction down; down subtracts, saturates at 0, then direction up; no wrap.
REQ-018 blink_cnt SHALL count period_end events; at limit-1 it SHALL reset to 0 and toggle blink_phase.
REQ-019 LED outputs SHALL be registered: one clock latency from pwm_cnt/state to pin; o_mode SHALL equal the current state register.
REQ-020 Output and state updates SHALL NOT glitch: no combinational path from inputs to outputs.

Reset
REQ-021 While i_reset=0: o_led_r/g/b=0, o_mode=0, prescaler, pwm_cnt, blink_cnt, envelope, active duty and fault_flag = 0; direction up, blink_phase=1.
REQ-022 Reset assertion mid-operation SHALL clear state immediately (asynchronous); deassertion SHALL resume counting from 0 on the next clock edge.

Verification
REQ-023 PRESCALE_TICKS=2, DUTY_WIDTH=4, RUN, i_brightness=4 -> o_led_g high 4 steps (8 clocks) of every 16-step (32-clock) period; brightness 0 -> always low.
REQ-024 RUN, change i_brightness 4->12 mid-period -> old duty holds to period_end; next period high 12 of 16 steps.
REQ-025 CALIB, DUTY_WIDTH=4, BREATH_STEP=4 -> envelope per period 4,8,12,15,11,7,3,0,4; o_led_b duty tracks one period later.
REQ-026 INIT, BLINK_PERIODS=2 -> red PWM-on during 2 periods, dark 2 periods, repeating; raise i_adc_init_done -> o_mode=1 next cycle, red 0.
REQ-027 RUN, pulse i_fault 1 cycle -> o_mode=3, red blinks full on/off, green 0; i_fault_clear with i_fault=1 -> stays FAULT; i_fault_clear with i_fault=0 -> RUN.
REQ-028 CALIB mid-breath, drive i_reset=0 asynchronously between edges -> all outputs 0 and o_mode=0 without waiting for a clock edge.
